// File: rtl/alu_result_buffer.sv
// alu_result_buffer: DEPTH-entry result FIFO behind the 64-bit ALU.
// Each accepted ALU result is stored with its fsec opcode and the derived
// {illegal, neg, zero} flags, then drained through a valid/ready handshake.
// Sticky last-result flags feed branch logic; a sticky overflow flag records
// any result dropped because the buffer was full.
// Optional feature: define ALU_BUF_DROP_CNT_EN to add a saturating 16-bit
// drop counter output (drop_cnt).
module alu_result_buffer #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [W-1:0]             in_data,
   input  logic [4:0]               in_fsec,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [W-1:0]             out_data,
   output logic [4:0]               out_fsec,
   output logic [2:0]               out_flags,
   output logic                     last_zero,
   output logic                     last_neg,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   count
`ifdef ALU_BUF_DROP_CNT_EN
   ,
   output logic [15:0]              drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Highest opcode the ALU actually implements; anything above is illegal.
   localparam logic [4:0] FSEC_MAX = 5'd14;

   // Flags packed as {illegal, neg, zero}.
   function automatic logic [2:0] calc_flags(input logic [W-1:0] d, input logic [4:0] f);
      calc_flags = {(f > FSEC_MAX), d[W-1], (d == '0)};
   endfunction

`ifdef ALU_BUF_DROP_CNT_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
`endif

   // Storage is deliberately left unreset; occupancy decides what is valid.
   logic [W-1:0] data_mem_q  [DEPTH];
   logic [4:0]   fsec_mem_q  [DEPTH];
   logic [2:0]   flags_mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          last_zero_q, last_zero_d;
   logic          last_neg_q,  last_neg_d;
   logic          overflow_q,  overflow_d;
`ifdef ALU_BUF_DROP_CNT_EN
   logic [15:0]   drop_cnt_q,  drop_cnt_d;
`endif

   logic       push, pop, drop;
   logic [2:0] in_flags;

   // Full/empty come from occupancy only, never from pointer comparison.
   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign drop      = in_valid & ~in_ready;
   assign in_flags  = calc_flags(in_data, in_fsec);

   // Head of the FIFO is presented combinationally; it only moves on a pop.
   assign out_data  = data_mem_q[rd_ptr_q];
   assign out_fsec  = fsec_mem_q[rd_ptr_q];
   assign out_flags = flags_mem_q[rd_ptr_q];

   assign last_zero = last_zero_q;
   assign last_neg  = last_neg_q;
   assign overflow  = overflow_q;
   assign count     = count_q;
`ifdef ALU_BUF_DROP_CNT_EN
   assign drop_cnt  = drop_cnt_q;
`endif

   // Next-state for pointers, occupancy and sticky status.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      last_zero_d = last_zero_q;
      last_neg_d  = last_neg_q;
      overflow_d  = overflow_q;
`ifdef ALU_BUF_DROP_CNT_EN
      drop_cnt_d  = drop_cnt_q;
`endif
      if (push) begin
         wr_ptr_d    = wr_ptr_q + AW'(1);
         last_zero_d = in_flags[0];
         last_neg_d  = in_flags[1];
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (drop) begin
         overflow_d = 1'b1;
`ifdef ALU_BUF_DROP_CNT_EN
         drop_cnt_d = sat_inc16(drop_cnt_q);
`endif
      end
   end

   // Control state register; reset overrides any push/pop in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         last_zero_q <= 1'b0;
         last_neg_q  <= 1'b0;
         overflow_q  <= 1'b0;
`ifdef ALU_BUF_DROP_CNT_EN
         drop_cnt_q  <= '0;
`endif
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         last_zero_q <= last_zero_d;
         last_neg_q  <= last_neg_d;
         overflow_q  <= overflow_d;
`ifdef ALU_BUF_DROP_CNT_EN
         drop_cnt_q  <= drop_cnt_d;
`endif
      end
   end

   // Entry write at the tail; suppressed while reset is asserted.
   always_ff @(posedge clk) begin
      if (push && rst_n) begin
         data_mem_q[wr_ptr_q]  <= in_data;
         fsec_mem_q[wr_ptr_q]  <= in_fsec;
         flags_mem_q[wr_ptr_q] <= in_flags;
      end
   end

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: table vectors plus hand-written sequences against a
// queue-based scoreboard for alu_result_buffer (DEPTH=4, W=64).
module tb_alu_result_buffer;

   localparam int DEPTH = 4;
   localparam int W     = 64;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [4:0]    in_fsec;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [4:0]    out_fsec;
   logic [2:0]    out_flags;
   logic          last_zero;
   logic          last_neg;
   logic          overflow;
   logic [2:0]    count;
`ifdef ALU_BUF_DROP_CNT_EN
   logic [15:0]   drop_cnt;
`endif

   alu_result_buffer #(.DEPTH(DEPTH), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_fsec   (in_fsec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_fsec  (out_fsec),
      .out_flags (out_flags),
      .last_zero (last_zero),
      .last_neg  (last_neg),
      .overflow  (overflow),
      .count     (count)
`ifdef ALU_BUF_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic [4:0]  fsec;
      logic [2:0]  exp_flags;
      logic        exp_lz;
      logic        exp_ln;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      logic [4:0]  fsec;
      logic [2:0]  flags;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic        m_ovf  = 1'b0;
   logic        m_lz   = 1'b0;
   logic        m_ln   = 1'b0;
   logic [15:0] m_drop = 16'd0;
   logic [2:0]  drv_flags;

   function automatic logic [2:0] mflags(input logic [63:0] d, input logic [4:0] f);
      logic ill;
      ill = (f >= 5'd15);
      mflags = {ill, d[63], (d == 64'd0)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: scoreboard the handshake before the edge, check state after it.
   task automatic tick();
      bit   do_push;
      bit   do_pop;
      exp_t e;
      if (!rst_n) begin
         sb.delete();
         m_ovf  = 1'b0;
         m_lz   = 1'b0;
         m_ln   = 1'b0;
         m_drop = 16'd0;
      end else begin
         chk("in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
         chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
         do_push = in_valid && (sb.size() < DEPTH);
         do_pop  = out_ready && (sb.size() != 0);
         if (do_pop) begin
            e = sb.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_fsec", 64'(out_fsec), 64'(e.fsec));
            chk("out_flags", 64'(out_flags), 64'(e.flags));
         end
         if (do_push) begin
            e.data  = in_data;
            e.fsec  = in_fsec;
            e.flags = drv_flags;
            sb.push_back(e);
            m_lz = drv_flags[0];
            m_ln = drv_flags[1];
         end else if (in_valid) begin
            m_ovf = 1'b1;
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
         end
      end
      @(posedge clk);
      #1;
      chk("count", 64'(count), 64'(sb.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("last_zero", 64'(last_zero), 64'(m_lz));
      chk("last_neg", 64'(last_neg), 64'(m_ln));
`ifdef ALU_BUF_DROP_CNT_EN
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
   endtask

   task automatic drive(input bit v, input logic [63:0] d, input logic [4:0] f,
                        input logic [2:0] fl, input bit r);
      in_valid  = v;
      in_data   = d;
      in_fsec   = f;
      drv_flags = fl;
      out_ready = r;
      tick();
   endtask

   task automatic push_gen(input logic [63:0] d, input logic [4:0] f, input bit r);
      drive(1'b1, d, f, mflags(d, f), r);
   endtask

   task automatic idle(input bit r);
      drive(1'b0, 64'd0, 5'd0, 3'd0, r);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
   endtask

   vec_t vecs[7];

   initial begin
      logic [63:0] hold_data;
      logic [4:0]  hold_fsec;
      logic [2:0]  hold_flags;

      vecs[0] = '{64'h5,                  5'd2,  3'b000, 1'b0, 1'b0};
      vecs[1] = '{64'h0,                  5'd8,  3'b001, 1'b1, 1'b0};
      vecs[2] = '{64'h8000_0000_0000_0000, 5'd3,  3'b010, 1'b0, 1'b1};
      vecs[3] = '{64'h0,                  5'd31, 3'b101, 1'b1, 1'b0};
      vecs[4] = '{64'h0,                  5'd15, 3'b101, 1'b1, 1'b0};
      vecs[5] = '{64'h1,                  5'd14, 3'b000, 1'b0, 1'b0};
      vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 5'd0,  3'b010, 1'b0, 1'b1};

      rst_n = 1'b0;
      in_valid = 1'b0; in_data = '0; in_fsec = '0; out_ready = 1'b0; drv_flags = '0;
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // First push visible on the head one cycle later.
      drive(1'b1, 64'h5, 5'b00010, 3'b000, 1'b0);
      chk("t1_out_valid", 64'(out_valid), 64'd1);
      chk("t1_out_data", out_data, 64'h5);
      chk("t1_out_fsec", 64'(out_fsec), 64'd2);
      chk("t1_out_flags", 64'(out_flags), 64'd0);
      chk("t1_count", 64'(count), 64'd1);
      drain();

      // Flag table: push into empty buffer, check sticky flags, then pop.
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, vecs[i].data, vecs[i].fsec, vecs[i].exp_flags, 1'b0);
         chk("vec_flags", 64'(out_flags), 64'(vecs[i].exp_flags));
         chk("vec_last_zero", 64'(last_zero), 64'(vecs[i].exp_lz));
         chk("vec_last_neg", 64'(last_neg), 64'(vecs[i].exp_ln));
         idle(1'b1);
      end

      // Fill, hold stability, overflow with and without out_ready.
      for (int i = 1; i <= 4; i++) push_gen(64'(i), 5'd1, 1'b0);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_count", 64'(count), 64'd4);
      hold_data = out_data; hold_fsec = out_fsec; hold_flags = out_flags;
      idle(1'b0);
      idle(1'b0);
      chk("hold_data", out_data, hold_data);
      chk("hold_fsec", 64'(out_fsec), 64'(hold_fsec));
      chk("hold_flags", 64'(out_flags), 64'(hold_flags));
      push_gen(64'h5, 5'd1, 1'b0);
      chk("ovf_set", 64'(overflow), 64'd1);
      push_gen(64'h6, 5'd1, 1'b1);
      chk("full_pop_count", 64'(count), 64'd3);
      drain();
      chk("ovf_sticky", 64'(overflow), 64'd1);

      // Steady push+pop at count 2 across pointer wrap.
      push_gen(64'hA0, 5'd4, 1'b0);
      push_gen(64'hA1, 5'd5, 1'b0);
      for (int i = 0; i < 10; i++) push_gen(64'hB0 + 64'(i), 5'(i), 1'b1);
      chk("steady_count", 64'(count), 64'd2);
      drain();

      // Reset mid-drain with a push pending.
      for (int i = 0; i < 3; i++) push_gen(64'hC0 + 64'(i), 5'd6, 1'b0);
      push_gen(64'hC3, 5'd6, 1'b1);
      chk("pre_rst_count", 64'(count), 64'd3);
      rst_n = 1'b0;
      push_gen(64'hC4, 5'd6, 1'b1);
      rst_n = 1'b1;
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_overflow", 64'(overflow), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      push_gen(64'hD0, 5'd7, 1'b0);
      idle(1'b1);

`ifdef ALU_BUF_DROP_CNT_EN
      // Saturation of the drop counter.
      for (int i = 0; i < 4; i++) push_gen(64'hE0 + 64'(i), 5'd1, 1'b0);
      push_gen(64'hEE, 5'd1, 1'b0);
      chk("drop_one", 64'(drop_cnt), 64'd1);
      in_valid = 1'b1;
      repeat (65540) @(posedge clk);
      #1;
      m_drop = 16'hFFFF;
      chk("drop_sat", 64'(drop_cnt), 64'hFFFF);
      push_gen(64'hEF, 5'd1, 1'b0);
      chk("drop_hold", 64'(drop_cnt), 64'hFFFF);
      drain();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
